// File: rtl/glitch_sweep_sequencer_pkg.sv
// Shared widths, FSM state encoding and helpers for the glitch sweep sequencer.
package glitch_sweep_sequencer_pkg;

  localparam int W     = 32;
  localparam int REP_W = 8;
  localparam int TMO_W = 24;
  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_CLEAR = 3'd4,
    S_STEP  = 3'd5,
    S_END   = 3'd6
  } state_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/glitch_sweep_sequencer_if.sv
// Bundle of the sequencer's configuration, trigger handshake and status signals.
interface glitch_sweep_sequencer_if;
  import glitch_sweep_sequencer_pkg::*;

  logic             i_START;
  logic             i_ABORT;
  logic             i_STOP_ON_HIT;
  logic [W-1:0]     i_D_START;
  logic [W-1:0]     i_D_STEP;
  logic [W-1:0]     i_D_END;
  logic [W-1:0]     i_P_START;
  logic [W-1:0]     i_P_STEP;
  logic [W-1:0]     i_P_END;
  logic [REP_W-1:0] i_REPEAT;
  logic [TMO_W-1:0] i_TIMEOUT;
  logic             i_DONE;
  logic             i_HIT;
  logic [W-1:0]     o_DELAY_1ST;
  logic [W-1:0]     o_PULSE_WIDTH;
  logic             o_ARM;
  logic             o_STOP_N;
  logic             o_BUSY;
  logic             o_FINISHED;
  logic             o_HIT_VALID;
  logic [W-1:0]     o_HIT_DELAY;
  logic [W-1:0]     o_HIT_WIDTH;
  logic [CNT_W-1:0] o_ATTEMPTS;
  logic [CNT_W-1:0] o_HITS;
  logic [CNT_W-1:0] o_TIMEOUTS;
  logic [2:0]       o_STATE;

  modport slave (
    input  i_START, i_ABORT, i_STOP_ON_HIT, i_D_START, i_D_STEP, i_D_END,
           i_P_START, i_P_STEP, i_P_END, i_REPEAT, i_TIMEOUT, i_DONE, i_HIT,
    output o_DELAY_1ST, o_PULSE_WIDTH, o_ARM, o_STOP_N, o_BUSY, o_FINISHED,
           o_HIT_VALID, o_HIT_DELAY, o_HIT_WIDTH, o_ATTEMPTS, o_HITS, o_TIMEOUTS, o_STATE
  );

  modport master (
    output i_START, i_ABORT, i_STOP_ON_HIT, i_D_START, i_D_STEP, i_D_END,
           i_P_START, i_P_STEP, i_P_END, i_REPEAT, i_TIMEOUT, i_DONE, i_HIT,
    input  o_DELAY_1ST, o_PULSE_WIDTH, o_ARM, o_STOP_N, o_BUSY, o_FINISHED,
           o_HIT_VALID, o_HIT_DELAY, o_HIT_WIDTH, o_ATTEMPTS, o_HITS, o_TIMEOUTS, o_STATE
  );

endinterface

// File: rtl/glitch_sweep_sequencer_sweep_axis.sv
// One sweep axis: holds its range and current value, steps with overflow-safe wrap.
module glitch_sweep_sequencer_sweep_axis
  import glitch_sweep_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic [W-1:0] cfg_start,
  input  logic [W-1:0] cfg_step,
  input  logic [W-1:0] cfg_end,
  input  logic         advance,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic [W-1:0] value_q, value_d;
  logic [W-1:0] start_q, start_d;
  logic [W-1:0] step_q, step_d;
  logic [W-1:0] end_q, end_d;
  logic [W:0]   next_sum;

  // Next value is computed one bit wider so a step past 2^W reads as a wrap, not a small value.
  always_comb begin
    next_sum = {1'b0, value_q} + {1'b0, step_q};
    wrap     = (step_q == '0) || next_sum[W] || (next_sum[W-1:0] > end_q);
    value_d  = value_q;
    start_d  = start_q;
    step_d   = step_q;
    end_d    = end_q;
    if (init) begin
      start_d = cfg_start;
      step_d  = cfg_step;
      end_d   = cfg_end;
      value_d = cfg_start;
    end else if (advance) begin
      value_d = wrap ? start_q : next_sum[W-1:0];
    end
  end

  // Axis range and position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      start_q <= '0;
      step_q  <= '0;
      end_q   <= '0;
    end else begin
      value_q <= value_d;
      start_q <= start_d;
      step_q  <= step_d;
      end_q   <= end_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/glitch_sweep_sequencer.sv
// Hardware-paced glitch sweep: width (outer) x delay (inner) x repeats, one trigger attempt each.
module glitch_sweep_sequencer
  import glitch_sweep_sequencer_pkg::*;
(
  input  logic                    i_CLK,
  input  logic                    i_RST_N,
  glitch_sweep_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic             arm_q, arm_d, stop_n_q, stop_n_d, busy_q, busy_d, finished_q, finished_d;
  logic [REP_W-1:0] rep_q, rep_d, rep_cfg_q, rep_cfg_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_cfg_q, tmo_cfg_d;
  logic             hit_lat_q, hit_lat_d, abort_q, abort_d, last_q, last_d, stop_cfg_q, stop_cfg_d;
  logic [CNT_W-1:0] attempts_q, attempts_d, hits_q, hits_d, timeouts_q, timeouts_d;
  logic             hit_valid_q, hit_valid_d;
  logic [W-1:0]     hit_delay_q, hit_delay_d, hit_width_q, hit_width_d;
  logic             axis_init, d_adv, p_adv, d_wrap, p_wrap;
  logic [W-1:0]     d_val, p_val;
  logic             attempt_hit, timed_out, rep_last, abort_req;

  glitch_sweep_sequencer_sweep_axis u_delay_axis (
    .clk(i_CLK), .rst_n(i_RST_N), .init(axis_init),
    .cfg_start(bus.i_D_START), .cfg_step(bus.i_D_STEP), .cfg_end(bus.i_D_END),
    .advance(d_adv), .value(d_val), .wrap(d_wrap)
  );

  glitch_sweep_sequencer_sweep_axis u_width_axis (
    .clk(i_CLK), .rst_n(i_RST_N), .init(axis_init),
    .cfg_start(bus.i_P_START), .cfg_step(bus.i_P_STEP), .cfg_end(bus.i_P_END),
    .advance(p_adv), .value(p_val), .wrap(p_wrap)
  );

  // Sweep control: points advance in CLEAR so new parameters settle during STEP before ARM rises.
  always_comb begin
    state_d     = state_q;
    arm_d       = arm_q;
    stop_n_d    = 1'b1;
    busy_d      = busy_q;
    finished_d  = 1'b0;
    rep_d       = rep_q;
    tmo_d       = tmo_q;
    hit_lat_d   = hit_lat_q;
    abort_d     = abort_q;
    last_d      = last_q;
    attempts_d  = attempts_q;
    hits_d      = hits_q;
    timeouts_d  = timeouts_q;
    hit_valid_d = hit_valid_q;
    hit_delay_d = hit_delay_q;
    hit_width_d = hit_width_q;
    rep_cfg_d   = rep_cfg_q;
    tmo_cfg_d   = tmo_cfg_q;
    stop_cfg_d  = stop_cfg_q;
    axis_init   = 1'b0;
    d_adv       = 1'b0;
    p_adv       = 1'b0;
    attempt_hit = hit_lat_q | bus.i_HIT;
    timed_out   = (tmo_cfg_q != '0) && (tmo_q >= tmo_cfg_q - TMO_W'(1));
    rep_last    = (rep_cfg_q == '0) || (rep_q >= rep_cfg_q - REP_W'(1));
    abort_req   = bus.i_ABORT && !abort_q && (state_q != S_IDLE) && (state_q != S_END);

    if (abort_req) begin
      state_d  = S_CLEAR;
      arm_d    = 1'b0;
      stop_n_d = 1'b0;
      abort_d  = 1'b1;
    end else begin
      case (state_q)
        S_LOAD: begin
          state_d   = S_ARM;
          arm_d     = 1'b1;
          tmo_d     = '0;
          hit_lat_d = 1'b0;
        end
        S_ARM: begin
          state_d = S_WAIT;
          tmo_d   = tmo_q + TMO_W'(1);
        end
        S_WAIT: begin
          hit_lat_d = attempt_hit;
          if (bus.i_DONE || timed_out) begin
            state_d    = S_CLEAR;
            arm_d      = 1'b0;
            stop_n_d   = 1'b0;
            attempts_d = sat_inc(attempts_q);
            if (!bus.i_DONE) timeouts_d = sat_inc(timeouts_q);
            if (attempt_hit) begin
              hits_d = sat_inc(hits_q);
              if (!hit_valid_q) begin
                hit_valid_d = 1'b1;
                hit_delay_d = d_val;
                hit_width_d = p_val;
              end
            end
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        S_CLEAR: begin
          if (abort_q) begin
            state_d    = S_END;
            busy_d     = 1'b0;
            finished_d = 1'b1;
          end else begin
            state_d = S_STEP;
            last_d  = 1'b0;
            if (rep_last && !(hit_lat_q && stop_cfg_q)) begin
              d_adv  = !(d_wrap && p_wrap);
              p_adv  = d_wrap && !p_wrap;
              last_d = d_wrap && p_wrap;
            end
          end
        end
        S_STEP: begin
          if ((hit_lat_q && stop_cfg_q) || last_q) begin
            state_d    = S_END;
            busy_d     = 1'b0;
            finished_d = 1'b1;
          end else begin
            state_d   = S_ARM;
            arm_d     = 1'b1;
            tmo_d     = '0;
            hit_lat_d = 1'b0;
            rep_d     = rep_last ? '0 : rep_q + REP_W'(1);
          end
        end
        default: begin
          if (state_q == S_END) state_d = S_IDLE;
          if (bus.i_START && !bus.i_ABORT) begin
            state_d     = S_LOAD;
            busy_d      = 1'b1;
            axis_init   = 1'b1;
            rep_d       = '0;
            hit_lat_d   = 1'b0;
            abort_d     = 1'b0;
            last_d      = 1'b0;
            attempts_d  = '0;
            hits_d      = '0;
            timeouts_d  = '0;
            hit_valid_d = 1'b0;
            hit_delay_d = '0;
            hit_width_d = '0;
            rep_cfg_d   = bus.i_REPEAT;
            tmo_cfg_d   = bus.i_TIMEOUT;
            stop_cfg_d  = bus.i_STOP_ON_HIT;
          end
        end
      endcase
    end
  end

  // All FSM state, registered outputs and counters; STOP_N idles high out of reset.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q     <= S_IDLE;
      arm_q       <= 1'b0;
      stop_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      rep_q       <= '0;
      tmo_q       <= '0;
      hit_lat_q   <= 1'b0;
      abort_q     <= 1'b0;
      last_q      <= 1'b0;
      attempts_q  <= '0;
      hits_q      <= '0;
      timeouts_q  <= '0;
      hit_valid_q <= 1'b0;
      hit_delay_q <= '0;
      hit_width_q <= '0;
      rep_cfg_q   <= '0;
      tmo_cfg_q   <= '0;
      stop_cfg_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_q       <= arm_d;
      stop_n_q    <= stop_n_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      rep_q       <= rep_d;
      tmo_q       <= tmo_d;
      hit_lat_q   <= hit_lat_d;
      abort_q     <= abort_d;
      last_q      <= last_d;
      attempts_q  <= attempts_d;
      hits_q      <= hits_d;
      timeouts_q  <= timeouts_d;
      hit_valid_q <= hit_valid_d;
      hit_delay_q <= hit_delay_d;
      hit_width_q <= hit_width_d;
      rep_cfg_q   <= rep_cfg_d;
      tmo_cfg_q   <= tmo_cfg_d;
      stop_cfg_q  <= stop_cfg_d;
    end
  end

  assign bus.o_DELAY_1ST   = d_val;
  assign bus.o_PULSE_WIDTH = p_val;
  assign bus.o_ARM         = arm_q;
  assign bus.o_STOP_N      = stop_n_q;
  assign bus.o_BUSY        = busy_q;
  assign bus.o_FINISHED    = finished_q;
  assign bus.o_HIT_VALID   = hit_valid_q;
  assign bus.o_HIT_DELAY   = hit_delay_q;
  assign bus.o_HIT_WIDTH   = hit_width_q;
  assign bus.o_ATTEMPTS    = attempts_q;
  assign bus.o_HITS        = hits_q;
  assign bus.o_TIMEOUTS    = timeouts_q;
  assign bus.o_STATE       = state_q;

endmodule

// File: tb/tb_glitch_sweep_sequencer.sv
// Randomized and directed bench for the glitch sweep sequencer against a point-list model.
module tb_glitch_sweep_sequencer;
  import glitch_sweep_sequencer_pkg::*;

  typedef struct {
    longint dS, dSt, dE, pS, pSt, pE;
    int     rep, tmo, doneLat, abortAt;
    bit     stopHit, hitEn;
    longint hd, hw;
  } cfg_t;

  logic clk = 1'b0;
  logic rstN;
  int   checkCount = 0;
  int   failCount  = 0;
  logic [31:0] expD[$];
  logic [31:0] expP[$];

  glitch_sweep_sequencer_if bus();

  glitch_sweep_sequencer dut (
    .i_CLK   (clk),
    .i_RST_N (rstN),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Number of points on one axis: start, start+step, ... while <= end; degenerate ranges give one point.
  function automatic longint axisCount(input longint s, input longint st, input longint e);
    if (st == 0 || s > e) return 1;
    return (e - s) / st + 1;
  endfunction

  function automatic cfg_t defaultCfg();
    cfg_t c;
    c.dS = 0; c.dSt = 1; c.dE = 0; c.pS = 0; c.pSt = 1; c.pE = 0;
    c.rep = 1; c.tmo = 0; c.doneLat = 3; c.abortAt = 0;
    c.stopHit = 0; c.hitEn = 0; c.hd = 0; c.hw = 0;
    return c;
  endfunction

  // Expected attempt order as (delay, width) pairs plus the number of hitting attempts.
  task automatic buildModel(input cfg_t c, output int nHits);
    longint nd, np;
    int     reps;
    bit     stop;
    longint dv, pv;
    nd = axisCount(c.dS, c.dSt, c.dE);
    np = axisCount(c.pS, c.pSt, c.pE);
    reps = (c.rep == 0) ? 1 : c.rep;
    stop = 0;
    nHits = 0;
    expD.delete();
    expP.delete();
    for (longint pi = 0; pi < np && !stop; pi++)
      for (longint di = 0; di < nd && !stop; di++)
        for (int r = 0; r < reps && !stop; r++) begin
          dv = c.dS + di * c.dSt;
          pv = c.pS + pi * c.pSt;
          expD.push_back(dv[31:0]);
          expP.push_back(pv[31:0]);
          if (c.hitEn && dv == c.hd && pv == c.hw) begin
            nHits++;
            if (c.stopHit) stop = 1;
          end
        end
  endtask

  // Runs one full sweep with a behavioural trigger/target stub and checks the outcome.
  task automatic applyStimulus(input string name, input cfg_t c);
    int nHits, cyc, endCyc, rises, seqErr, stabErr, lenErr, firstArm;
    int stopLow, finCnt, armCycles, armLen, abortOk, expAtt;
    bit prevArm;
    logic [31:0] prevD, prevP;
    buildModel(c, nHits);
    expAtt = (c.abortAt != 0) ? 0 : expD.size();
    bus.i_D_START = c.dS[31:0]; bus.i_D_STEP = c.dSt[31:0]; bus.i_D_END = c.dE[31:0];
    bus.i_P_START = c.pS[31:0]; bus.i_P_STEP = c.pSt[31:0]; bus.i_P_END = c.pE[31:0];
    bus.i_REPEAT = c.rep[7:0]; bus.i_TIMEOUT = c.tmo[23:0]; bus.i_STOP_ON_HIT = c.stopHit;
    @(negedge clk);
    bus.i_START = 1'b1;
    cyc = 0; endCyc = -1; rises = 0; seqErr = 0; stabErr = 0; lenErr = 0; firstArm = -1;
    stopLow = 0; finCnt = 0; armCycles = 0; armLen = 0; abortOk = 0;
    prevArm = 1'b0; prevD = bus.o_DELAY_1ST; prevP = bus.o_PULSE_WIDTH;
    while ((endCyc < 0 || cyc < endCyc + 3) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.i_START = 1'b0;
      if (cyc == 3) begin
        bus.i_START = 1'b1;
        bus.i_D_START = $urandom; bus.i_P_START = $urandom; bus.i_REPEAT = 8'($urandom);
      end
      if (cyc == 4) bus.i_START = 1'b0;
      if (c.abortAt != 0 && cyc == c.abortAt) bus.i_ABORT = 1'b1;
      if (c.abortAt != 0 && cyc == c.abortAt + 1) begin
        bus.i_ABORT = 1'b0;
        if (!bus.o_ARM && !bus.o_STOP_N) abortOk++;
      end
      if (c.abortAt != 0 && cyc == c.abortAt + 2 && bus.o_FINISHED) abortOk++;
      if (bus.o_ARM && !prevArm) begin
        if (firstArm < 0) firstArm = cyc;
        if (bus.o_DELAY_1ST !== prevD || bus.o_PULSE_WIDTH !== prevP) stabErr++;
        if (rises < expD.size()) begin
          if (bus.o_DELAY_1ST !== expD[rises] || bus.o_PULSE_WIDTH !== expP[rises]) seqErr++;
        end else begin
          seqErr++;
        end
        rises++;
        armLen = 0;
      end
      if (bus.o_ARM) armLen++;
      if (!bus.o_ARM && prevArm && c.doneLat == 0 && c.tmo != 0 && armLen != c.tmo) lenErr++;
      if (!bus.o_STOP_N) stopLow++;
      if (bus.o_FINISHED) begin
        finCnt++;
        if (endCyc < 0) endCyc = cyc;
      end
      armCycles = bus.o_ARM ? armCycles + 1 : 0;
      bus.i_DONE = bus.o_ARM && c.doneLat != 0 && armCycles >= c.doneLat;
      bus.i_HIT  = bus.o_ARM && c.hitEn && bus.o_DELAY_1ST == c.hd[31:0] && bus.o_PULSE_WIDTH == c.hw[31:0];
      prevArm = bus.o_ARM; prevD = bus.o_DELAY_1ST; prevP = bus.o_PULSE_WIDTH;
    end
    checkOutput({name, " sweep_ended"}, 64'(endCyc >= 0), 64'd1);
    checkOutput({name, " finished_pulses"}, 64'(finCnt), 64'd1);
    checkOutput({name, " arm_latency"}, 64'(firstArm), 64'd2);
    checkOutput({name, " arm_rises"}, 64'(rises), 64'((c.abortAt != 0) ? 1 : expD.size()));
    checkOutput({name, " point_order_errs"}, 64'(seqErr), 64'd0);
    checkOutput({name, " param_stable_errs"}, 64'(stabErr), 64'd0);
    checkOutput({name, " timeout_len_errs"}, 64'(lenErr), 64'd0);
    checkOutput({name, " attempts"}, 64'(bus.o_ATTEMPTS), 64'(expAtt));
    checkOutput({name, " hits"}, 64'(bus.o_HITS), 64'((c.abortAt != 0) ? 0 : nHits));
    checkOutput({name, " timeouts"}, 64'(bus.o_TIMEOUTS), 64'((c.doneLat == 0 && c.tmo != 0) ? expAtt : 0));
    checkOutput({name, " stop_n_low"}, 64'(stopLow), 64'((c.abortAt != 0) ? 1 : expAtt));
    checkOutput({name, " hit_valid"}, 64'(bus.o_HIT_VALID), 64'(nHits > 0 && c.abortAt == 0));
    checkOutput({name, " hit_delay"}, 64'(bus.o_HIT_DELAY), (nHits > 0) ? 64'(c.hd) : 64'd0);
    checkOutput({name, " hit_width"}, 64'(bus.o_HIT_WIDTH), (nHits > 0) ? 64'(c.hw) : 64'd0);
    checkOutput({name, " idle_busy"}, 64'(bus.o_BUSY), 64'd0);
    checkOutput({name, " idle_state"}, 64'(bus.o_STATE), 64'd0);
    if (c.abortAt != 0) checkOutput({name, " abort_timing"}, 64'(abortOk), 64'd2);
  endtask

  initial begin
    cfg_t c;
    longint nd, np;
    rstN = 1'b0;
    bus.i_START = 0; bus.i_ABORT = 0; bus.i_STOP_ON_HIT = 0; bus.i_DONE = 0; bus.i_HIT = 0;
    bus.i_D_START = 0; bus.i_D_STEP = 0; bus.i_D_END = 0;
    bus.i_P_START = 0; bus.i_P_STEP = 0; bus.i_P_END = 0;
    bus.i_REPEAT = 0; bus.i_TIMEOUT = 0;
    #12;
    checkOutput("reset arm", 64'(bus.o_ARM), 64'd0);
    checkOutput("reset stop_n", 64'(bus.o_STOP_N), 64'd1);
    checkOutput("reset busy", 64'(bus.o_BUSY), 64'd0);
    checkOutput("reset attempts", 64'(bus.o_ATTEMPTS), 64'd0);
    checkOutput("reset state", 64'(bus.o_STATE), 64'd0);
    @(negedge clk);
    rstN = 1'b1;

    // ABORT together with START in IDLE must not start a sweep.
    @(negedge clk);
    bus.i_START = 1'b1; bus.i_ABORT = 1'b1;
    @(negedge clk);
    bus.i_START = 1'b0; bus.i_ABORT = 1'b0;
    @(negedge clk);
    checkOutput("start_abort_idle busy", 64'(bus.o_BUSY), 64'd0);
    checkOutput("start_abort_idle stop_n", 64'(bus.o_STOP_N), 64'd1);

    c = defaultCfg(); c.dE = 4; c.dSt = 2; c.pS = 10; c.pE = 10;
    applyStimulus("d_step2", c);
    c = defaultCfg(); c.dE = 1; c.pS = 5; c.pE = 7; c.rep = 2;
    applyStimulus("rep2_grid", c);
    c = defaultCfg(); c.dE = 2; c.pS = 1; c.pE = 1; c.doneLat = 0; c.tmo = 8;
    applyStimulus("timeout8", c);
    c = defaultCfg(); c.dE = 8; c.dSt = 2; c.pS = 10; c.pE = 10;
    c.hitEn = 1; c.stopHit = 1; c.hd = 4; c.hw = 10;
    applyStimulus("stop_on_hit", c);
    c = defaultCfg(); c.dS = 64'hFFFF_FFFE; c.dSt = 4; c.dE = 64'hFFFF_FFFF; c.pS = 10; c.pE = 10;
    applyStimulus("overflow", c);
    c = defaultCfg(); c.dE = 3; c.doneLat = 0; c.tmo = 0; c.abortAt = 6;
    applyStimulus("abort", c);

    // Asynchronous reset in the middle of a waiting attempt clears everything at once.
    bus.i_D_START = 7; bus.i_D_STEP = 1; bus.i_D_END = 9; bus.i_TIMEOUT = 0; bus.i_REPEAT = 1;
    @(negedge clk);
    bus.i_START = 1'b1;
    @(negedge clk);
    bus.i_START = 1'b0;
    repeat (5) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("async_reset arm", 64'(bus.o_ARM), 64'd0);
    checkOutput("async_reset busy", 64'(bus.o_BUSY), 64'd0);
    checkOutput("async_reset delay", 64'(bus.o_DELAY_1ST), 64'd0);
    checkOutput("async_reset state", 64'(bus.o_STATE), 64'd0);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < 6; i++) begin
      c = defaultCfg();
      c.dS = $urandom_range(0, 8); c.dSt = $urandom_range(0, 4); c.dE = $urandom_range(0, 12);
      c.pS = $urandom_range(0, 8); c.pSt = $urandom_range(0, 4); c.pE = $urandom_range(0, 12);
      c.rep = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        c.doneLat = $urandom_range(2, 5);
        c.tmo = ($urandom_range(0, 1) == 1) ? 20 : 0;
      end else begin
        c.doneLat = 0;
        c.tmo = $urandom_range(2, 6);
      end
      c.hitEn = 1'($urandom_range(0, 1));
      c.stopHit = 1'($urandom_range(0, 1));
      nd = axisCount(c.dS, c.dSt, c.dE);
      np = axisCount(c.pS, c.pSt, c.pE);
      c.hd = c.dS + longint'($urandom_range(0, int'(nd - 1))) * c.dSt;
      c.hw = c.pS + longint'($urandom_range(0, int'(np - 1))) * c.pSt;
      applyStimulus($sformatf("rand%0d", i), c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
